result_reader: RTL and testbench
================================

RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter ADDR_W, default 13, output-memory address width.
REQ-002 Parameter DATA_W, default 16, output-memory word width.
REQ-003 Ports: clock  in  1  single clock, all state on rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: finish  in  1  solver completion flag (level); negcycle  in  1  solver negative-cycle flag.
REQ-006 Ports: num_nodes  in  ADDR_W+1  entry count, sampled at start.
REQ-007 Ports: omar  out  ADDR_W  output-memory read address; omdr  in  DATA_W  combinational read data, same cycle as omar.
REQ-008 Ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_W; out_index  out  ADDR_W; out_unreach  out  1; out_neg  out  1; out_last  out  1.
REQ-009 Ports: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL stream distance entries 0..num_nodes-1 from output memory to a valid/ready port after solver completion.
REQ-011 SHALL detect start as finish==1 with registered finish_q==0, in IDLE only; starts while not IDLE are ignored.
REQ-012 SHALL use states IDLE, STREAM, NEG, DONE.
REQ-013 IDLE -> NEG when start and negcycle==1; IDLE -> DONE when start, negcycle==0, num_nodes==0; otherwise IDLE -> STREAM with read pointer 0.
REQ-014 In STREAM, omar = read pointer; omdr is captured into the output register when it is empty or accepted that cycle (out_valid && out_ready).
REQ-015 First beat (index 0) SHALL have out_valid high the cycle after the start edge; sustained throughput one beat/cycle with out_ready held high.
REQ-016 Beat transfers only on out_valid && out_ready; out_data/out_index/flags SHALL hold stable while out_valid && !out_ready.
REQ-017 out_unreach = 1 exactly when out_data == 16'hFFFF; out_neg = 0 in STREAM beats.
REQ-018 out_last = 1 on index num_nodes-1; its acceptance -> DONE; read pointer never advances past num_nodes-1 (no address wrap).
REQ-019 num_nodes above 2**ADDR_W SHALL be clamped to 2**ADDR_W (last index 8191).
REQ-020 NEG: emit one beat out_data=16'hFFFF, out_index=0, out_neg=1, out_unreach=1, out_last=1, no memory reads; acceptance -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; a new start requires finish to fall and rise again.
REQ-022 busy = 1 in STREAM, NEG, DONE; 0 in IDLE.
REQ-023 omar = 0 whenever not in STREAM.

Reset
REQ-024 reset low SHALL asynchronously force IDLE, pointer 0, finish_q 0, and all outputs 0 (out_valid, out_data, out_index, flags, omar, busy, done).
REQ-025 Reset mid-transfer SHALL drop any pending beat; no partial beat appears after release.
REQ-026 If finish is already high at reset release, start SHALL NOT fire until finish falls and rises.

Structure
REQ-027 Shared package bf_pkg SHALL hold ADDR_W, DATA_W, INF_DIST=16'hFFFF, and the state enum.
REQ-028 One sub-module, result_slice (single-entry valid/ready output register), SHALL hold data/index/flags; FSM and pointer live in result_reader.

Verification
REQ-029 num_nodes=4, memory {5,FFFF,0,12}, ready high, finish rises -> beats idx0..3 on consecutive cycles, unreach only idx1, last on idx3, done one cycle later.
REQ-030 Same data, out_ready toggling 1/0 -> all four beats delivered in order, outputs stable during stalls, no duplicates or drops.
REQ-031 finish and negcycle rise together -> single beat FFFF, out_neg=1, out_last=1, omar stays 0, then done.
REQ-032 num_nodes=0, finish rises -> no beats, done pulses, busy high only for DONE cycle.
REQ-033 reset asserted after beat 2 of 8, finish still high -> all outputs 0 at once; after release, no stream until finish falls and rises.
REQ-034 num_nodes=8192, ready high -> 8192 beats, last index 8191, no index wrap.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the result reader.
//   ADDR_W / DATA_W : default output-memory address and word widths
//   INF_DIST        : distance value that marks an unreachable node
//   rr_state_e      : result reader FSM states
package bf_pkg;

    localparam int          ADDR_W   = 13;
    localparam int          DATA_W   = 16;
    localparam logic [15:0] INF_DIST = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_NEG    = 2'd2,
        ST_DONE   = 2'd3
    } rr_state_e;

endpackage

// File: rtl/result_slice.sv
// result_slice: single-entry valid/ready output register holding one beat.
// A beat is loaded when 'load' is high; the caller only loads when the
// register is empty or its current beat is accepted in the same cycle.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   load              : capture in_* into the register (sets out_valid)
//   in_*              : beat fields to capture
//   out_ready         : downstream acceptance
//   out_valid, out_*  : registered beat presented downstream
module result_slice #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_index,
    input  logic              in_unreach,
    input  logic              in_neg,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_unreach,
    output logic              out_neg,
    output logic              out_last
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              unreach_q, unreach_d;
    logic              neg_q, neg_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;
        unreach_d = unreach_q;
        neg_d     = neg_q;
        last_d    = last_q;
        if (load) begin
            valid_d   = 1'b1;
            data_d    = in_data;
            index_d   = in_index;
            unreach_d = in_unreach;
            neg_d     = in_neg;
            last_d    = in_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            unreach_q <= 1'b0;
            neg_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
            unreach_q <= unreach_d;
            neg_q     <= neg_d;
            last_q    <= last_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_index   = index_q;
    assign out_unreach = unreach_q;
    assign out_neg     = neg_q;
    assign out_last    = last_q;

endmodule

// File: rtl/result_reader.sv
// result_reader: after the solver finishes, streams distance entries
// 0..num_nodes-1 from the output memory onto a valid/ready port, or a single
// negative-cycle marker beat when the solver reports a negative cycle.
// Ports:
//   clock, reset       : clock, asynchronous active-low reset
//   finish, negcycle   : solver completion / negative-cycle flags (levels)
//   num_nodes          : entry count, sampled at start, clamped to 2**ADDR_W
//   omar, omdr         : output-memory address / combinational read data
//   out_*              : valid/ready result stream
//   busy, done         : transfer in progress / one-cycle completion pulse
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a rising edge of finish
// ST_STREAM | reading memory entries into the output register
// ST_NEG    | presenting the single negative-cycle beat
// ST_DONE   | one-cycle done pulse, then back to idle
module result_reader
    import bf_pkg::rr_state_e;
    import bf_pkg::ST_IDLE;
    import bf_pkg::ST_STREAM;
    import bf_pkg::ST_NEG;
    import bf_pkg::ST_DONE;
    import bf_pkg::INF_DIST;
#(
    parameter int ADDR_W = bf_pkg::ADDR_W,
    parameter int DATA_W = bf_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              negcycle,
    input  logic [ADDR_W:0]   num_nodes,
    output logic [ADDR_W-1:0] omar,
    input  logic [DATA_W-1:0] omdr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_unreach,
    output logic              out_neg,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] INF_W = DATA_W'(INF_DIST);

    rr_state_e         state_q, state_d;
    logic              finish_q, finish_d;
    // armed_q stays low after reset until finish has been seen low, so a
    // finish that is already high at reset release cannot start a transfer.
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    // issued_q: the last entry has been read; the pointer parks on it.
    logic              issued_q, issued_d;

    logic              start;
    logic              fetch;
    logic              accept;
    logic              nodes_zero;
    logic [ADDR_W-1:0] nodes_last;

    logic              load;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] ld_index;
    logic              ld_neg;
    logic              ld_last;

    assign start  = (state_q == ST_IDLE) && finish && !finish_q && armed_q;
    assign accept = out_valid && out_ready;
    assign fetch  = (state_q == ST_STREAM) && !issued_q && (!out_valid || out_ready);

    // Counts of 2**ADDR_W or more all map to a last index of 2**ADDR_W-1.
    assign nodes_zero = (num_nodes == '0);
    assign nodes_last = num_nodes[ADDR_W] ? '1 : (num_nodes[ADDR_W-1:0] - ADDR_W'(1));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (negcycle) begin
                        state_d = ST_NEG;
                    end else if (nodes_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (accept && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_NEG: begin
                if (accept) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        omar     = '0;
        load     = 1'b0;
        ld_data  = omdr;
        ld_index = ptr_q;
        ld_neg   = 1'b0;
        ld_last  = (ptr_q == last_idx_q);
        case (state_q)
            ST_IDLE: begin
                // The marker beat is loaded on the start edge itself; no
                // memory access is involved.
                if (start && negcycle) begin
                    load     = 1'b1;
                    ld_data  = INF_W;
                    ld_index = '0;
                    ld_neg   = 1'b1;
                    ld_last  = 1'b1;
                end
            end
            ST_STREAM: begin
                omar = ptr_q;
                load = fetch;
            end
            default: begin
            end
        endcase
    end

    // Pointer, finish edge detection and last-index bookkeeping
    always_comb begin
        finish_d   = finish;
        armed_d    = armed_q | ~finish;
        ptr_d      = ptr_q;
        last_idx_d = last_idx_q;
        issued_d   = issued_q;
        if (start) begin
            ptr_d      = '0;
            issued_d   = 1'b0;
            last_idx_d = nodes_last;
        end else if (fetch) begin
            if (ptr_q == last_idx_q) begin
                issued_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end else if (state_q == ST_DONE) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finish_q   <= 1'b0;
            armed_q    <= 1'b0;
            ptr_q      <= '0;
            last_idx_q <= '0;
            issued_q   <= 1'b0;
        end else begin
            finish_q   <= finish_d;
            armed_q    <= armed_d;
            ptr_q      <= ptr_d;
            last_idx_q <= last_idx_d;
            issued_q   <= issued_d;
        end
    end

    result_slice #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slice (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .in_data     (ld_data),
        .in_index    (ld_index),
        .in_unreach  (ld_data == INF_W),
        .in_neg      (ld_neg),
        .in_last     (ld_last),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_unreach (out_unreach),
        .out_neg     (out_neg),
        .out_last    (out_last)
    );

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

    localparam int          AW  = 13;
    localparam int          DW  = 16;
    localparam int          MAXN = 8192;
    localparam logic [15:0] INF = 16'hFFFF;

    logic          clock;
    logic          reset;
    logic          finish;
    logic          negcycle;
    logic [AW:0]   num_nodes;
    logic [AW-1:0] omar;
    logic [DW-1:0] omdr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_unreach;
    logic          out_neg;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [15:0] mem [0:MAXN-1];
    assign omdr = mem[omar];

    result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .finish      (finish),
        .negcycle    (negcycle),
        .num_nodes   (num_nodes),
        .omar        (omar),
        .omdr        (omdr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_unreach (out_unreach),
        .out_neg     (out_neg),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [15:0] d, input logic [12:0] i,
                                         input logic u, input logic ng, input logic l);
        return {u, ng, l, i, d};
    endfunction

    function automatic logic [31:0] observed();
        return pack(out_data, out_index, out_unreach, out_neg, out_last);
    endfunction

    // Reference: the list of beats the port must deliver, in order.
    task automatic build_expected(input int n_eff, input bit neg);
        exp_q.delete();
        if (neg) begin
            exp_q.push_back(pack(INF, 13'd0, 1'b1, 1'b1, 1'b1));
        end else begin
            for (int i = 0; i < n_eff; i++) begin
                exp_q.push_back(pack(mem[i], 13'(i), mem[i] == INF, 1'b0, i == n_eff - 1));
            end
        end
    endtask

    // mode 0: ready held high, 1: ready toggling, 2: random ready + finish glitches
    task automatic run(input int n, input bit neg, input int mode, input int stop_after);
        int n_eff, lim, cyc, acc, first_cyc, exp_done;
        bit have_prev, done_seen;
        logic [31:0] prev;
        @(negedge clock);
        finish    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_eff = neg ? 1 : ((n > MAXN) ? MAXN : n);
        lim   = (n_eff == 0) ? 1 : n_eff;
        build_expected(n_eff, neg);
        num_nodes = 14'(n);
        negcycle  = neg;
        finish    = 1'b1;
        cyc = 0; acc = 0; first_cyc = -1; have_prev = 0; done_seen = 0; prev = '0;
        exp_done = neg ? 2 : ((n_eff == 0) ? 1 : n_eff + 2);
        while (!done_seen && cyc < n_eff * 4 + 20) begin
            @(negedge clock);
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && cyc > 2 && $urandom_range(0, 15) == 0) finish = ~finish;
            #1;
            chk("busy", 64'(busy), 64'(1));
            chk("omar_range", 64'(int'(omar) < lim), 64'(1));
            if (have_prev) chk("stall_hold", 64'({out_valid, observed()}), 64'({1'b1, prev}));
            have_prev = out_valid && !out_ready;
            prev      = observed();
            if (out_valid && first_cyc < 0) begin
                first_cyc = cyc;
                chk("first_latency", 64'(cyc), neg ? 64'(1) : 64'(2));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'(observed()), 64'(0));
                else                   chk("beat", 64'(observed()), 64'(exp_q.pop_front()));
                acc++;
            end
            if (done) begin
                done_seen = 1;
                chk("beats_left", 64'(exp_q.size()), 64'(0));
                if (mode == 0) chk("done_latency", 64'(cyc), 64'(exp_done));
            end
            if (stop_after >= 0 && acc >= stop_after) return;
        end
        if (!done_seen) chk("timeout", 64'(0), 64'(1));
        if (mode == 2) finish = 1'b0;
        // finish stays high in modes 0/1: no restart may follow
        repeat (3) begin
            @(negedge clock);
            #1;
            chk("post_done", 64'({done, busy, out_valid, omar}), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b0; finish = 1'b1; negcycle = 1'b0; out_ready = 1'b0; num_nodes = 14'd4;
        for (int i = 0; i < MAXN; i++)
            mem[i] = ($urandom_range(0, 4) == 0) ? INF : 16'($urandom);
        #3;
        chk("reset_outs", 64'({out_valid, out_data, out_index, out_unreach, out_neg, out_last, omar, busy, done}), 64'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        // finish already high at reset release: must not start
        repeat (6) begin
            @(negedge clock);
            #1;
            chk("no_start_at_release", 64'({busy, out_valid}), 64'(0));
        end

        mem[0] = 16'd5; mem[1] = INF; mem[2] = 16'd0; mem[3] = 16'd12;
        run(4, 0, 0, -1);
        run(4, 0, 1, -1);
        run(4, 1, 0, -1);
        run(7, 1, 1, -1);
        run(0, 0, 0, -1);
        run(1, 0, 0, -1);

        // reset in the middle of an 8-entry stream
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        run(8, 0, 0, 2);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 chk("mid_reset_outs", 64'({out_valid, out_data, out_index, out_unreach, out_neg, out_last, omar, busy, done}), 64'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            #1;
            chk("no_stream_after_reset", 64'({busy, out_valid}), 64'(0));
        end
        run(8, 0, 1, -1);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 48; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? INF : 16'($urandom);
            run($urandom_range(1, 40), ($urandom_range(0, 5) == 0), $urandom_range(0, 2), -1);
        end

        run(8192, 0, 0, -1);
        run(12000, 0, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
